// File: rtl/cic_decim_ctrl.sv
// Sequencer for the order-3 CIC decimator: derives clk_dec, captures and scales
// one filter output per decimated period, and hands samples downstream via a 2-entry buffer.
module cic_decim_ctrl #(
  parameter  int IN_W   = 16,
  parameter  int M_MAX  = 64,
  parameter  int M_INIT = 64,
  parameter  int OUT_W  = 16,
  parameter  int WARMUP = 6,
  localparam int CIC_W  = IN_W + $clog2(M_MAX**3),
  localparam int RW     = $clog2(M_MAX+1),
  localparam int SW     = $clog2(CIC_W)
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic [RW-1:0]    cfg_ratio,
  input  logic [SW-1:0]    cfg_shift,
  input  logic             cfg_load,
  output logic             cfg_busy,
  output logic             cfg_err,
  output logic             clk_dec,
  input  logic [CIC_W-1:0] cic_out,
  output logic [OUT_W-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             sat,
  output logic             ovf,
  input  logic             flag_clr
);

  localparam int WW = $clog2(WARMUP+1);
  localparam logic signed [CIC_W-1:0] P_MAX = CIC_W'((2**(OUT_W-1)) - 1);
  localparam logic signed [CIC_W-1:0] P_MIN = ~P_MAX;

  logic [RW-1:0]    r_cnt;
  logic [RW-1:0]    r_ratio;
  logic [RW-1:0]    r_pend_val;
  logic             r_pend;
  logic             r_err;
  logic             r_clk_dec;
  logic [WW-1:0]    r_warm;
  logic [1:0]       r_level;
  logic [OUT_W-1:0] r_head;
  logic [OUT_W-1:0] r_tail;
  logic             r_sat;
  logic             r_ovf;

  logic                    w_wrap;
  logic                    w_apply;
  logic [RW-1:0]           w_ratio_nxt;
  logic [RW-1:0]           w_cnt_nxt;
  logic [RW:0]             w_half;
  logic                    w_legal;
  logic                    w_cap;
  logic                    w_push;
  logic                    w_pop;
  logic signed [CIC_W-1:0] w_shifted;
  logic                    w_hi;
  logic                    w_lo;
  logic [OUT_W-1:0]        w_sample;

  always_comb begin
    w_wrap      = (r_cnt == r_ratio - RW'(1));
    w_apply     = w_wrap && r_pend;
    w_ratio_nxt = w_apply ? r_pend_val : r_ratio;
    w_cnt_nxt   = w_wrap ? '0 : r_cnt + RW'(1);
    // High phase is ceil(R/2) counts, evaluated against the ratio in force after this edge
    w_half      = ({1'b0, w_ratio_nxt} + (RW+1)'(1)) >> 1;
    w_legal     = (cfg_ratio >= RW'(4)) && (cfg_ratio <= RW'(M_MAX));
    w_cap       = (r_cnt == RW'(2));
    w_push      = w_cap && (r_warm == '0);
    w_pop       = (r_level != 2'd0) && m_ready;
    w_shifted   = $signed(cic_out) >>> cfg_shift;
    w_hi        = (w_shifted > P_MAX);
    w_lo        = (w_shifted < P_MIN);
    if (w_hi)
      w_sample = {1'b0, {(OUT_W-1){1'b1}}};
    else if (w_lo)
      w_sample = {1'b1, {(OUT_W-1){1'b0}}};
    else
      w_sample = w_shifted[OUT_W-1:0];
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_ratio   <= RW'(M_INIT);
      r_clk_dec <= 1'b1;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_ratio   <= w_ratio_nxt;
      r_clk_dec <= ({1'b0, w_cnt_nxt} < w_half);
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_pend     <= 1'b0;
      r_pend_val <= '0;
      r_err      <= 1'b0;
    end else begin
      r_err <= cfg_load && !w_legal;
      // A legal load in the wrap cycle re-arms for the following wrap
      if (cfg_load && w_legal) begin
        r_pend     <= 1'b1;
        r_pend_val <= cfg_ratio;
      end else if (w_apply) begin
        r_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset)
      r_warm <= WW'(WARMUP);
    else if (w_apply)
      r_warm <= WW'(WARMUP);
    else if (w_cap && (r_warm != '0))
      r_warm <= r_warm - WW'(1);
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_level <= 2'd0;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      unique case ({w_push, w_pop})
        2'b10: begin
          if (r_level == 2'd0) begin
            r_head  <= w_sample;
            r_level <= 2'd1;
          end else if (r_level == 2'd1) begin
            r_tail  <= w_sample;
            r_level <= 2'd2;
          end
        end
        2'b01: begin
          r_head  <= r_tail;
          r_level <= r_level - 2'd1;
        end
        2'b11: begin
          if (r_level == 2'd1) begin
            r_head <= w_sample;
          end else begin
            r_head <= r_tail;
            r_tail <= w_sample;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_sat <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      if (w_push && (w_hi || w_lo))
        r_sat <= 1'b1;
      else if (flag_clr)
        r_sat <= 1'b0;
      if (w_push && !w_pop && (r_level == 2'd2))
        r_ovf <= 1'b1;
      else if (flag_clr)
        r_ovf <= 1'b0;
    end
  end

  assign cfg_busy = r_pend;
  assign cfg_err  = r_err;
  assign clk_dec  = r_clk_dec;
  assign m_data   = r_head;
  assign m_valid  = (r_level != 2'd0);
  assign sat      = r_sat;
  assign ovf      = r_ovf;

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// Directed bench for cic_decim_ctrl: expected samples are queued at capture time
// and a monitor checks every valid/ready transfer against the queue head.
module tb_cic_decim_ctrl;

  localparam int CIC_W = 34;

  logic                    clk_in   = 1'b0;
  logic                    reset    = 1'b1;
  logic [6:0]              cfg_ratio = '0;
  logic [5:0]              cfg_shift = '0;
  logic                    cfg_load = 1'b0;
  logic                    cfg_busy;
  logic                    cfg_err;
  logic                    clk_dec;
  logic signed [CIC_W-1:0] cic_out  = '0;
  logic [15:0]             m_data;
  logic                    m_valid;
  logic                    m_ready  = 1'b0;
  logic                    sat;
  logic                    ovf;
  logic                    flag_clr = 1'b0;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mon_e;

  always #5 clk_in = ~clk_in;

  cic_decim_ctrl #(
    .IN_W(16), .M_MAX(64), .M_INIT(64), .OUT_W(16), .WARMUP(6)
  ) dut (
    .clk_in(clk_in), .reset(reset),
    .cfg_ratio(cfg_ratio), .cfg_shift(cfg_shift), .cfg_load(cfg_load),
    .cfg_busy(cfg_busy), .cfg_err(cfg_err), .clk_dec(clk_dec),
    .cic_out(cic_out), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .sat(sat), .ovf(ovf), .flag_clr(flag_clr)
  );

  // Monitor: one pop per transfer, sampled just after the falling edge
  always begin
    @(negedge clk_in);
    #1;
    if (!reset && m_valid && m_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL xfer_unexpected: got m_data=%h, required no transfer", m_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (m_data !== mon_e) begin
          fails++;
          $display("FAIL xfer_data: got %h, required %h", m_data, mon_e);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic wait_rise();
    logic prev;
    prev = clk_dec;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk_in);
      if (!prev && clk_dec) return;
      prev = clk_dec;
    end
    tests++;
    fails++;
    $display("FAIL clk_dec_rise: got no rise in 300 cycles, required a rise");
  endtask

  // Starts on the sample right after a clk_dec rise; ends on the next rise
  task automatic measure(output int hi, output int per);
    logic prev;
    hi  = 0;
    per = 0;
    for (int n = 0; n < 300; n++) begin
      if (clk_dec) hi++;
      per++;
      prev = clk_dec;
      @(negedge clk_in);
      if (!prev && clk_dec) return;
    end
    tests++;
    fails++;
    $display("FAIL clk_dec_period: got no second rise in 300 cycles, required one");
  endtask

  task automatic goto_cap();
    wait_rise();
    tick(2);
  endtask

  task automatic cap(input logic signed [CIC_W-1:0] v, input logic [5:0] sh,
                     input bit push, input logic [15:0] e);
    cic_out   = v;
    cfg_shift = sh;
    if (push) exp_q.push_back(e);
    tick(1);
  endtask

  task automatic pulse_load(input logic [6:0] r);
    cfg_ratio = r;
    cfg_load  = 1'b1;
    tick(1);
    cfg_load  = 1'b0;
  endtask

  task automatic pulse_clr();
    flag_clr = 1'b1;
    tick(1);
    flag_clr = 1'b0;
  endtask

  // Entered in the first cycle after reset release with R back at 64
  task automatic warmup_seq(input logic [15:0] val);
    int hi, per;
    cic_out   = CIC_W'(val);
    cfg_shift = '0;
    m_ready   = 1'b1;
    wait_rise();
    measure(hi, per);
    check("period64_high", 64'(hi), 64'd32);
    check("period64_len", 64'(per), 64'd64);
    check("warm_no_valid", 64'(m_valid), 64'd0);
    tick(2);
    for (int i = 3; i <= 6; i++) begin
      cap(CIC_W'(val), 6'd0, 1'b0, 16'd0);
      check("warm_discard", 64'(m_valid), 64'd0);
      goto_cap();
    end
    cap(CIC_W'(val), 6'd0, 1'b1, val);
    check("first_valid", 64'(m_valid), 64'd1);
    check("first_data", 64'(m_data), 64'(val));
  endtask

  initial begin
    int hi, per;

    // Reset state
    repeat (3) @(negedge clk_in);
    #1;
    check("rst_clk_dec", 64'(clk_dec), 64'd1);
    check("rst_outputs", 64'({m_valid, cfg_busy, cfg_err, sat, ovf, m_data}), 64'd0);
    @(negedge clk_in);
    reset = 1'b0;

    // 1: R=64 warm-up, first sample on capture 7
    warmup_seq(16'd1000);
    check("sat_idle", 64'(sat), 64'd0);

    // 2: scaling and saturation
    goto_cap();
    cap(34'sd1048576, 6'd2, 1'b1, 16'h7FFF);
    check("sat_pos_set", 64'(sat), 64'd1);
    pulse_clr();
    check("sat_cleared", 64'(sat), 64'd0);
    goto_cap();
    flag_clr = 1'b1;
    cap(-34'sd1048576, 6'd2, 1'b1, 16'h8000);
    flag_clr = 1'b0;
    check("sat_set_beats_clr", 64'(sat), 64'd1);
    pulse_clr();
    goto_cap();
    cap(-34'sd1000, 6'd1, 1'b1, 16'hFE0C);
    check("sat_after_neg_inrange", 64'(sat), 64'd0);
    goto_cap();
    cap(34'sd65534, 6'd1, 1'b1, 16'h7FFF);
    check("sat_at_max_exact", 64'(sat), 64'd0);
    goto_cap();
    cap(34'sd65536, 6'd1, 1'b1, 16'h7FFF);
    check("sat_just_over", 64'(sat), 64'd1);
    pulse_clr();

    // 3: backpressure fills buffer, third sample dropped
    goto_cap();
    m_ready = 1'b0;
    cap(34'sd111, 6'd0, 1'b1, 16'd111);
    goto_cap();
    cap(34'sd222, 6'd0, 1'b1, 16'd222);
    check("hold_head", 64'(m_data), 64'd111);
    goto_cap();
    cap(34'sd333, 6'd0, 1'b0, 16'd0);
    check("ovf_set", 64'(ovf), 64'd1);
    check("full_head_unchanged", 64'(m_data), 64'd111);
    tick(1);
    m_ready = 1'b1;
    tick(3);
    check("drained", 64'(m_valid), 64'd0);
    pulse_clr();
    check("ovf_cleared", 64'(ovf), 64'd0);

    // 5: illegal ratios rejected
    pulse_load(7'd3);
    check("err_low_ratio", 64'(cfg_err), 64'd1);
    check("busy_after_illegal", 64'(cfg_busy), 64'd0);
    tick(1);
    check("err_one_cycle", 64'(cfg_err), 64'd0);
    pulse_load(7'd65);
    check("err_high_ratio", 64'(cfg_err), 64'd1);
    tick(1);
    check("busy_still_low", 64'(cfg_busy), 64'd0);
    cic_out   = 34'sd777;
    cfg_shift = '0;
    exp_q.push_back(16'd777);
    wait_rise();
    measure(hi, per);
    check("period_kept_64", 64'(per), 64'd64);

    // 4: ratio change to 8 (pending value overwritten 16 -> 8)
    tick(2);
    cap(34'sd555, 6'd0, 1'b1, 16'd555);
    tick(7);
    pulse_load(7'd16);
    check("busy_set", 64'(cfg_busy), 64'd1);
    tick(2);
    pulse_load(7'd8);
    check("busy_on_overwrite", 64'(cfg_busy), 64'd1);
    wait_rise();
    check("busy_dropped_at_wrap", 64'(cfg_busy), 64'd0);
    cic_out = 34'sd500;
    measure(hi, per);
    check("period8_high", 64'(hi), 64'd4);
    check("period8_len", 64'(per), 64'd8);
    tick(2);
    for (int i = 2; i <= 6; i++) begin
      cap(34'sd500, 6'd0, 1'b0, 16'd0);
      check("r8_warm_discard", 64'(m_valid), 64'd0);
      goto_cap();
    end
    cap(34'sd500, 6'd0, 1'b1, 16'd500);
    check("r8_first_valid", 64'(m_valid), 64'd1);

    // 6: reset with buffered samples
    goto_cap();
    m_ready = 1'b0;
    cap(34'sd10, 6'd0, 1'b0, 16'd0);
    goto_cap();
    cap(34'sd20, 6'd0, 1'b0, 16'd0);
    goto_cap();
    cap(34'sd30, 6'd0, 1'b0, 16'd0);
    check("r8_ovf", 64'(ovf), 64'd1);
    check("r8_hold_head", 64'(m_data), 64'd10);
    reset = 1'b1;
    #1;
    check("async_valid_drop", 64'(m_valid), 64'd0);
    check("async_clk_dec", 64'(clk_dec), 64'd1);
    check("async_flags", 64'({ovf, sat, m_data}), 64'd0);
    tick(2);
    reset = 1'b0;
    warmup_seq(16'd4242);

    tick(4);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
